// File: rtl/rename_map_table_if.sv
// Rename-stage bus: decode rename request, source lookups, active-list pairings, commit frees.
// The master side drives requests; the slave side (the map table) answers them.
interface rename_map_table_if;
  logic       rename_valid;
  logic       rename_ready;
  logic [4:0] rename_logical;
  logic [5:0] rename_physical;
  logic [4:0] src_a_logical;
  logic [4:0] src_b_logical;
  logic [5:0] src_a_physical;
  logic [5:0] src_b_physical;
  logic       add_mapping;
  logic [4:0] prev_logical_reg;
  logic [5:0] prev_physical_reg;
  logic       free_valid;
  logic [5:0] free_physical;
  logic       flush;
  logic       restore_valid;
  logic [4:0] restore_logical;
  logic [5:0] restore_physical;
  logic       restore_done;
  logic [6:0] free_count;
  logic       overflow_err;

  modport master (
    output rename_valid, rename_logical, src_a_logical, src_b_logical,
           free_valid, free_physical, flush, restore_valid,
           restore_logical, restore_physical, restore_done,
    input  rename_ready, rename_physical, src_a_physical, src_b_physical,
           add_mapping, prev_logical_reg, prev_physical_reg,
           free_count, overflow_err
  );

  modport slave (
    input  rename_valid, rename_logical, src_a_logical, src_b_logical,
           free_valid, free_physical, flush, restore_valid,
           restore_logical, restore_physical, restore_done,
    output rename_ready, rename_physical, src_a_physical, src_b_physical,
           add_mapping, prev_logical_reg, prev_physical_reg,
           free_count, overflow_err
  );
endinterface

// File: rtl/rename_map_table.sv
// Logical->physical map plus circular free list; lookups are zero-latency, updates land next cycle.
// rename_ready drops when the free list is empty, during flush, and throughout restore.
module rename_map_table (
  input  logic                clk,
  input  logic                rst,
  rename_map_table_if.slave   bus
);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_RESTORE = 1'b1
  } state_t;

  state_t     r_state;
  logic [5:0] r_map [32];
  logic [5:0] r_fl  [64];
  logic [5:0] r_head;
  logic [5:0] r_tail;
  logic [6:0] r_count;
  logic       r_add_mapping;
  logic [4:0] r_prev_logical;
  logic [5:0] r_prev_physical;
  logic       r_overflow;

  logic       w_ready;
  logic       w_alloc;
  logic       w_push0;
  logic       w_push1;
  logic       w_push0_ok;
  logic       w_push1_ok;
  logic [6:0] w_cnt_after0;
  logic [5:0] w_tail1;
  logic [5:0] w_squashed;

  assign w_ready      = (r_state == ST_NORMAL) && (r_count != 7'd0) && !bus.flush;
  assign w_alloc      = bus.rename_valid && w_ready && (bus.rename_logical != 5'd0);

  // Commit free takes the first slot, the squashed restore allocation the second.
  assign w_squashed   = r_map[bus.restore_logical];
  assign w_push0      = bus.free_valid;
  assign w_push1      = bus.restore_valid && (r_state == ST_RESTORE);
  assign w_push0_ok   = w_push0 && (r_count != 7'd64);
  assign w_cnt_after0 = r_count + {6'd0, w_push0_ok};
  assign w_push1_ok   = w_push1 && (w_cnt_after0 != 7'd64);
  assign w_tail1      = r_tail + {5'd0, w_push0_ok};

  assign bus.rename_ready      = w_ready;
  assign bus.rename_physical   = r_fl[r_head];
  assign bus.src_a_physical    = (bus.src_a_logical == 5'd0) ? 6'd0 : r_map[bus.src_a_logical];
  assign bus.src_b_physical    = (bus.src_b_logical == 5'd0) ? 6'd0 : r_map[bus.src_b_logical];
  assign bus.add_mapping       = r_add_mapping;
  assign bus.prev_logical_reg  = r_prev_logical;
  assign bus.prev_physical_reg = r_prev_physical;
  assign bus.free_count        = r_count;
  assign bus.overflow_err      = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_NORMAL;
      r_head          <= 6'd0;
      r_tail          <= 6'd32;
      r_count         <= 7'd32;
      r_add_mapping   <= 1'b0;
      r_prev_logical  <= 5'd0;
      r_prev_physical <= 6'd0;
      r_overflow      <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_map[i] <= 6'(i);
      end
      for (int i = 0; i < 64; i++) begin
        r_fl[i] <= (i < 32) ? 6'(i + 32) : 6'd0;
      end
    end else begin
      r_add_mapping <= w_alloc;

      case (r_state)
        ST_NORMAL:  if (bus.flush)        r_state <= ST_RESTORE;
        ST_RESTORE: if (bus.restore_done) r_state <= ST_NORMAL;
        default:                          r_state <= ST_NORMAL;
      endcase

      if (w_alloc) begin
        r_map[bus.rename_logical] <= r_fl[r_head];
        r_head                    <= r_head + 6'd1;
        r_prev_logical            <= bus.rename_logical;
        r_prev_physical           <= r_map[bus.rename_logical];
      end

      if (w_push1) begin
        r_map[bus.restore_logical] <= bus.restore_physical;
      end

      if (w_push0_ok) r_fl[r_tail]  <= bus.free_physical;
      if (w_push1_ok) r_fl[w_tail1] <= w_squashed;
      r_tail  <= w_tail1 + {5'd0, w_push1_ok};
      r_count <= w_cnt_after0 + {6'd0, w_push1_ok} - {6'd0, w_alloc};

      if ((w_push0 && !w_push0_ok) || (w_push1 && !w_push1_ok)) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
module tb_rename_map_table;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  rename_map_table_if u_if ();

  rename_map_table dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.rename_valid     = 1'b0;
    u_if.rename_logical   = 5'd0;
    u_if.src_a_logical    = 5'd0;
    u_if.src_b_logical    = 5'd0;
    u_if.free_valid       = 1'b0;
    u_if.free_physical    = 6'd0;
    u_if.flush            = 1'b0;
    u_if.restore_valid    = 1'b0;
    u_if.restore_logical  = 5'd0;
    u_if.restore_physical = 6'd0;
    u_if.restore_done     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_inputs();
    do_reset();

    // Reset state
    u_if.src_a_logical = 5'd7;
    u_if.src_b_logical = 5'd31;
    #1;
    chk("rst_count",     u_if.free_count, 32);
    chk("rst_addmap",    u_if.add_mapping, 0);
    chk("rst_prevl",     u_if.prev_logical_reg, 0);
    chk("rst_prevp",     u_if.prev_physical_reg, 0);
    chk("rst_ovf",       u_if.overflow_err, 0);
    chk("rst_ready",     u_if.rename_ready, 1);
    chk("rst_head",      u_if.rename_physical, 32);
    chk("rst_src_a",     u_if.src_a_physical, 7);
    chk("rst_src_b",     u_if.src_b_physical, 31);

    // Rename r5; source lookup in the accept cycle sees the old map
    u_if.rename_valid   = 1'b1;
    u_if.rename_logical = 5'd5;
    u_if.src_a_logical  = 5'd5;
    #1;
    chk("r5_phys",       u_if.rename_physical, 32);
    chk("r5_src_old",    u_if.src_a_physical, 5);
    tick();
    u_if.rename_valid = 1'b0;
    #1;
    chk("r5_addmap",     u_if.add_mapping, 1);
    chk("r5_prevl",      u_if.prev_logical_reg, 5);
    chk("r5_prevp",      u_if.prev_physical_reg, 5);
    chk("r5_src_new",    u_if.src_a_physical, 32);
    chk("r5_count",      u_if.free_count, 31);
    tick();
    chk("r5_pulse_end",  u_if.add_mapping, 0);

    // Rename r0 from reset: no allocation
    do_reset();
    u_if.rename_valid   = 1'b1;
    u_if.rename_logical = 5'd0;
    u_if.src_a_logical  = 5'd0;
    #1;
    chk("r0_ready",      u_if.rename_ready, 1);
    tick();
    u_if.rename_valid = 1'b0;
    #1;
    chk("r0_addmap",     u_if.add_mapping, 0);
    chk("r0_count",      u_if.free_count, 32);
    chk("r0_src",        u_if.src_a_physical, 0);
    chk("r0_head",       u_if.rename_physical, 32);

    // 32 back-to-back renames of r1 drain the free list
    do_reset();
    u_if.rename_logical = 5'd1;
    u_if.rename_valid   = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      chk("b2b_addmap", u_if.add_mapping, 1);
      chk("b2b_prevp",  u_if.prev_physical_reg, (i == 0) ? 1 : 31 + i);
    end
    chk("empty_count",   u_if.free_count, 0);
    chk("empty_ready",   u_if.rename_ready, 0);
    tick();
    chk("empty_noalloc", u_if.add_mapping, 0);
    u_if.rename_valid  = 1'b0;
    u_if.free_valid    = 1'b1;
    u_if.free_physical = 6'd40;
    #1;
    chk("free_same_cyc", u_if.rename_ready, 0);
    tick();
    u_if.free_valid = 1'b0;
    #1;
    chk("free_ready",    u_if.rename_ready, 1);
    chk("free_phys",     u_if.rename_physical, 40);
    chk("free_count1",   u_if.free_count, 1);

    // Allocate and free together at count 10
    do_reset();
    u_if.rename_logical = 5'd2;
    u_if.rename_valid   = 1'b1;
    for (int i = 0; i < 22; i++) tick();
    chk("cnt10",         u_if.free_count, 10);
    u_if.free_valid    = 1'b1;
    u_if.free_physical = 6'd2;
    tick();
    u_if.rename_valid = 1'b0;
    u_if.free_valid   = 1'b0;
    #1;
    chk("alloc_free",    u_if.free_count, 10);
    chk("alloc_free_am", u_if.add_mapping, 1);

    // Fill the free list to 64, then overflow
    do_reset();
    u_if.free_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      u_if.free_physical = 6'(i);
      tick();
    end
    chk("full_count",    u_if.free_count, 64);
    chk("full_noovf",    u_if.overflow_err, 0);
    u_if.free_physical = 6'd9;
    tick();
    u_if.free_valid = 1'b0;
    #1;
    chk("ovf_set",       u_if.overflow_err, 1);
    chk("ovf_count",     u_if.free_count, 64);
    tick();
    tick();
    chk("ovf_sticky",    u_if.overflow_err, 1);

    // Rename r3 twice, flush, restore youngest first
    do_reset();
    u_if.rename_logical = 5'd3;
    u_if.rename_valid   = 1'b1;
    #1;
    chk("r3a_phys",      u_if.rename_physical, 32);
    tick();
    chk("r3b_phys",      u_if.rename_physical, 33);
    tick();
    chk("r3b_prevp",     u_if.prev_physical_reg, 32);
    u_if.rename_logical = 5'd7;
    u_if.flush          = 1'b1;
    #1;
    chk("flush_ready",   u_if.rename_ready, 0);
    tick();
    u_if.flush = 1'b0;
    #1;
    chk("flush_noacc",   u_if.add_mapping, 0);
    chk("rest_ready",    u_if.rename_ready, 0);
    chk("rest_count0",   u_if.free_count, 30);
    u_if.rename_valid     = 1'b0;
    u_if.flush            = 1'b1;
    u_if.restore_valid    = 1'b1;
    u_if.restore_logical  = 5'd3;
    u_if.restore_physical = 6'd32;
    tick();
    u_if.flush = 1'b0;
    u_if.src_a_logical = 5'd3;
    #1;
    chk("rest_count1",   u_if.free_count, 31);
    chk("rest_map1",     u_if.src_a_physical, 32);
    u_if.restore_physical = 6'd3;
    u_if.restore_done     = 1'b1;
    tick();
    idle_inputs();
    u_if.src_a_logical = 5'd3;
    #1;
    chk("rest_map3",     u_if.src_a_physical, 3);
    chk("rest_count2",   u_if.free_count, 32);
    chk("rest_rdy_back", u_if.rename_ready, 1);
    u_if.rename_logical = 5'd4;
    u_if.rename_valid   = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("rest_push33",   u_if.rename_physical, 33);
    tick();
    u_if.rename_valid = 1'b0;
    #1;
    chk("rest_push32",   u_if.rename_physical, 32);

    // Reset mid-RESTORE
    do_reset();
    u_if.rename_logical = 5'd4;
    u_if.rename_valid   = 1'b1;
    tick();
    u_if.rename_valid = 1'b0;
    u_if.flush        = 1'b1;
    tick();
    u_if.flush            = 1'b0;
    u_if.restore_valid    = 1'b1;
    u_if.restore_logical  = 5'd4;
    u_if.restore_physical = 6'd9;
    tick();
    u_if.restore_valid = 1'b0;
    u_if.src_a_logical = 5'd4;
    #1;
    chk("mid_map9",      u_if.src_a_physical, 9);
    chk("mid_ready0",    u_if.rename_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_map",   u_if.src_a_physical, 4);
    chk("mid_rst_cnt",   u_if.free_count, 32);
    chk("mid_rst_rdy",   u_if.rename_ready, 1);
    tick();
    rst = 1'b0;
    #1;

    // Reset clears a pending add_mapping pulse immediately
    u_if.rename_logical = 5'd6;
    u_if.rename_valid   = 1'b1;
    tick();
    u_if.rename_valid = 1'b0;
    #1;
    chk("pend_addmap",   u_if.add_mapping, 1);
    rst = 1'b1;
    #1;
    chk("pend_cleared",  u_if.add_mapping, 0);
    chk("pend_prevl",    u_if.prev_logical_reg, 0);
    tick();
    rst = 1'b0;
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
